// File: rtl/bram_host_pkg.sv
// ============================================================================
// Module      : bram_host_pkg
// Description : Shared types and constants for the shared-BRAM host sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bram_host_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FILL      = 3'd1,
        WAIT_DONE = 3'd2,
        ACK       = 3'd3,
        DRAIN     = 3'd4,
        FINISH    = 3'd5,
        ERR       = 3'd6
    } state_t;

    localparam logic [3:0] C_WE_FULL = 4'hf;

    // BRAM 1 sits directly above BRAM 0 in the byte address space.
    function automatic int unsigned bram1_base(input int unsigned depth);
        return depth * 4;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bram_host_rdfifo.sv
// ============================================================================
// Module      : bram_host_rdfifo
// Description : 2-entry 32-bit registered FIFO buffering BRAM read data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_host_rdfifo (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic [31:0] pop_data,
    output logic [1:0]  count
);

    logic [31:0] r_mem [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;
    logic        w_do_push;
    logic        w_do_pop;

    assign w_do_push = push && ((r_count != 2'd2) || pop);
    assign w_do_pop  = pop && (r_count != 2'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Gated so the port reads zero whenever nothing is buffered.
    assign pop_data = (r_count != 2'd0) ? r_mem[r_rd_ptr] : 32'd0;
    assign count    = r_count;

endmodule

`default_nettype wire

// File: rtl/bram_host_seq.sv
// ============================================================================
// Module      : bram_host_seq
// Description : PL-side host: loads BRAM 0, runs the accelerator handshake and
//               streams BRAM 1 out. HOST_TIMEOUT_EN adds a handshake watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_host_seq
    import bram_host_pkg::*;
#(
    parameter int DEPTH   = 2048,
    parameter int TIMEOUT = 65535
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    input  logic [31:0]                in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [31:0]                out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH)+2:0]   bram_addr,
    output logic [31:0]                bram_wrdata,
    output logic [3:0]                 bram_we,
    output logic                       bram_en,
    input  logic [31:0]                bram_rddata,
    output logic [31:0]                ps_control,
    input  logic [31:0]                pl_status
);

    localparam int AW = $clog2(DEPTH) + 3;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] C_BRAM1_BASE = AW'(bram1_base(DEPTH));
    localparam logic [CW-1:0] C_DEPTH      = CW'(DEPTH);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_wr_cnt;
    logic [CW-1:0] r_rd_cnt;
    logic [CW-1:0] r_pop_cnt;
    logic          r_inflight;
    logic          w_issue;
    logic          w_pop;
    logic          w_ps_req;
    logic [1:0]    w_fifo_count;
    logic [2:0]    w_pending;
    logic          w_unused_status;

    assign w_unused_status = ^pl_status[31:1];

`ifdef HOST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] C_TO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] r_to_cnt;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
`endif

    assign out_valid = (w_fifo_count != 2'd0);
    assign w_pop     = out_valid && out_ready;
    assign w_pending = 3'(w_fifo_count) + 3'(r_inflight);
    assign busy      = (r_state != IDLE) && (r_state != ERR);
    assign ps_control = {31'd0, w_ps_req};

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        bram_en     = 1'b0;
        bram_we     = 4'h0;
        bram_addr   = '0;
        bram_wrdata = 32'd0;
        done        = 1'b0;
        w_ps_req    = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = FILL;
            end
            FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    bram_en     = 1'b1;
                    bram_we     = C_WE_FULL;
                    bram_addr   = {r_wr_cnt, 2'b00};
                    bram_wrdata = in_data;
                    if (r_wr_cnt + 1'b1 == C_DEPTH) w_state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                w_ps_req = 1'b1;
                if (pl_status[0]) w_state_nxt = ACK;
`ifdef HOST_TIMEOUT_EN
                else if (r_to_cnt == C_TO_LAST) w_state_nxt = ERR;
`endif
            end
            ACK: begin
                if (!pl_status[0]) w_state_nxt = DRAIN;
`ifdef HOST_TIMEOUT_EN
                else if (r_to_cnt == C_TO_LAST) w_state_nxt = ERR;
`endif
            end
            DRAIN: begin
                // A pop this cycle frees the slot the next read will land in.
                w_issue = (r_rd_cnt != C_DEPTH) &&
                          ((w_pending < 3'd2) || ((w_pending == 3'd2) && w_pop));
                if (w_issue) begin
                    bram_en   = 1'b1;
                    bram_addr = C_BRAM1_BASE + {r_rd_cnt, 2'b00};
                end
                if (w_pop && (r_pop_cnt + 1'b1 == C_DEPTH)) w_state_nxt = FINISH;
            end
            FINISH: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            ERR: begin
                if (start) w_state_nxt = FILL;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_pop_cnt  <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_issue;
            if (((r_state == IDLE) || (r_state == ERR)) && start) begin
                r_wr_cnt  <= '0;
                r_rd_cnt  <= '0;
                r_pop_cnt <= '0;
            end else begin
                if ((r_state == FILL) && in_valid) r_wr_cnt <= r_wr_cnt + 1'b1;
                if (w_issue) r_rd_cnt  <= r_rd_cnt + 1'b1;
                if (w_pop)   r_pop_cnt <= r_pop_cnt + 1'b1;
            end
        end
    end

`ifdef HOST_TIMEOUT_EN
    // Restarts on every state change so WAIT_DONE and ACK each get a full budget.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_to_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_to_cnt <= '0;
        end else if ((r_state == WAIT_DONE) || (r_state == ACK)) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign err = (r_state == ERR);
`else
    assign err = 1'b0;
`endif

    bram_host_rdfifo u_rdfifo (
        .clk       (clk),
        .reset     (reset),
        .push      (r_inflight),
        .push_data (bram_rddata),
        .pop       (w_pop),
        .pop_data  (out_data),
        .count     (w_fifo_count)
    );

endmodule

`default_nettype wire

// File: tb/tb_bram_host_seq.sv
// ============================================================================
// Module      : tb_bram_host_seq
// Description : Scoreboard bench with BRAM model and reversing accelerator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bram_host_seq;

    localparam int DEPTH  = 2048;
    localparam int AW     = $clog2(DEPTH) + 3;
    localparam int UP_DLY = 100;
    localparam int DN_DLY = 20;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, err, in_ready, out_valid, bram_en;
    logic [31:0]   in_data = 32'd0;
    logic          in_valid = 1'b0;
    logic [31:0]   out_data, bram_wrdata, ps_control;
    logic          out_ready;
    logic [AW-1:0] bram_addr;
    logic [3:0]    bram_we;
    logic [31:0]   bram_rddata = 32'd0;
    logic [31:0]   pl_status;

    logic [31:0] bram0 [DEPTH];
    logic [31:0] bram1 [DEPTH];

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] exp_q [$];
    int          beats = 0;
    int          done_cnt = 0;
    int          viol = 0;
    bit          bp = 1'b1;
    bit          resp_en = 1'b1;
    logic        stall_prev = 1'b0;
    logic [31:0] held = 32'd0;
    logic        prev_ps = 1'b0;
    logic        prev_st = 1'b0;

    always #5 clk = ~clk;

    bram_host_seq #(.DEPTH(DEPTH), .TIMEOUT(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .bram_addr   (bram_addr),
        .bram_wrdata (bram_wrdata),
        .bram_we     (bram_we),
        .bram_en     (bram_en),
        .bram_rddata (bram_rddata),
        .ps_control  (ps_control),
        .pl_status   (pl_status)
    );

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic [127:0] outs();
        return {8'd0, busy, done, err, in_ready, out_valid, out_data, bram_addr,
                bram_wrdata, bram_we, bram_en, ps_control};
    endfunction

    // BRAM pair: one-cycle read latency; bank 1 is only written by the accelerator.
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we == 4'hf && !bram_addr[AW-1]) bram0[bram_addr[AW-2:2]] <= bram_wrdata;
            bram_rddata <= bram_addr[AW-1] ? bram1[bram_addr[AW-2:2]] : bram0[bram_addr[AW-2:2]];
        end
    end

    // Reversing accelerator with level handshake.
    initial begin
        pl_status = 32'd0;
        forever begin
            @(posedge clk); #1;
            if (resp_en && ps_control[0]) begin
                repeat (UP_DLY - 1) @(posedge clk);
                #1;
                for (int k = 0; k < DEPTH; k++) bram1[k] = bram0[DEPTH-1-k];
                pl_status = {31'($urandom), 1'b1};
                while (ps_control[0]) begin @(posedge clk); #1; end
                repeat (DN_DLY - 1) @(posedge clk);
                #1;
                pl_status = {31'($urandom), 1'b0};
            end
        end
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: scoreboard pops, stall stability and protocol rules.
    always @(negedge clk) begin
        if (!reset) begin
            stall_prev = 1'b0;
            prev_ps    = 1'b0;
            prev_st    = 1'b0;
        end else begin
            if (stall_prev) check("stall_hold", {out_valid, out_data}, {1'b1, held});
            if (out_valid && out_ready) begin
                beats++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL extra_beat: got data %0h, expected no beat", out_data);
                end else begin
                    check("out_data", out_data, exp_q.pop_front());
                end
            end
            stall_prev = out_valid && !out_ready;
            held       = out_data;
            if (done) done_cnt++;
            if (bram_en && bram_we != 4'h0 && bram_addr[AW-1]) viol++;
            if (bram_we != 4'h0 && bram_we != 4'hf) viol++;
            if (!bram_en && (bram_we != 4'h0 || bram_addr != '0)) viol++;
            if (bram_en && bram_addr[AW-1] && pl_status[0]) viol++;
            if (prev_ps && !ps_control[0] && !prev_st && !err) viol++;
            prev_ps = ps_control[0];
            prev_st = pl_status[0];
        end
    end

    task automatic do_fill(input bit use_bp, input bit seq_data);
        int acc;
        int cyc;
        logic [31:0] words [$];
        acc = 0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = use_bp ? 1'($urandom_range(0, 1)) : 1'b1;
        in_data  = seq_data ? 32'd0 : $urandom;
        @(negedge clk);
        check("fill_entry", {busy, in_ready, ps_control[0]}, 3'b110);
        for (cyc = 0; acc < DEPTH && cyc < 20000; cyc++) begin
            if (in_valid && in_ready) begin
                words.push_back(in_data);
                acc++;
            end
            @(posedge clk); #1;
            start = use_bp && (acc == 100);
            if (acc < DEPTH) begin
                in_valid = use_bp ? 1'($urandom_range(0, 1)) : 1'b1;
                in_data  = seq_data ? 32'(acc) : $urandom;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("fill_count", acc, DEPTH);
        check("wait_done_entry", {busy, in_ready, ps_control[0]}, 3'b101);
        for (int k = words.size() - 1; k >= 0; k--) exp_q.push_back(words[k]);
    endtask

    task automatic wait_run_end();
        int c;
        int d0;
        c  = 0;
        d0 = done_cnt;
        while (done_cnt == d0 && c < 30000) begin
            @(negedge clk); #1;
            c++;
        end
        repeat (3) @(negedge clk);
        #1;
        check("done_pulses", done_cnt - d0, 1);
        check("beats", beats, DEPTH);
        check("sb_empty", exp_q.size(), 0);
        check("end_state", {busy, ps_control}, 33'd0);
        check("protocol_viol", viol, 0);
    endtask

    task automatic full_run(input bit use_bp, input bit seq_data);
        bp    = use_bp;
        beats = 0;
        viol  = 0;
        do_fill(use_bp, seq_data);
        wait_run_end();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int c;
        // Reset held low with random stimulus.
        bp = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            start    = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            in_data  = $urandom;
            @(negedge clk);
            check("reset_outs", outs(), 128'd0);
        end
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        check("post_reset_idle", {busy, in_ready, err, out_valid}, 4'd0);

        full_run(1'b0, 1'b1);
        full_run(1'b1, 1'b0);

        // Reset in the middle of draining.
        bp    = 1'b0;
        beats = 0;
        viol  = 0;
        do_fill(1'b0, 1'b0);
        c = 0;
        while (beats < 500 && c < 20000) begin
            @(negedge clk); #1;
            c++;
        end
        check("mid_beats_reached", beats >= 500, 1'b1);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("rst_mid_async", outs(), 128'd0);
        @(negedge clk);
        check("rst_mid_next", outs(), 128'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_release", {busy, out_valid, ps_control[0]}, 3'd0);
        full_run(1'b0, 1'b0);

        // Handshake that never completes.
        resp_en = 1'b0;
        bp      = 1'b0;
        do_fill(1'b0, 1'b0);
        exp_q.delete();
`ifdef HOST_TIMEOUT_EN
        c = 0;
        while (ps_control[0] && c < 100) begin
            c++;
            @(negedge clk);
        end
        check("timeout_cycles", c, 16);
        check("err_state", {err, ps_control, busy}, {1'b1, 32'd0, 1'b0});
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("err_restart", {err, in_ready, busy}, 3'b011);
`else
        repeat (200) @(negedge clk);
        check("stuck_wait", {ps_control[0], err, busy, in_ready}, 4'b1010);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bram_host_seq.md
# bram_host_seq

PL-side initiator for the shared-BRAM accelerator interface: it drives the byte-addressed BRAM port and the control/status handshake that the PS normally drives through the AXI BRAM controller and GPIO. It loads DEPTH words from an input stream into BRAM 0, starts the accelerator, and waits for completion. It then acknowledges completion and streams the DEPTH result words of BRAM 1 out. Used as a hardware host for PL-only integration and as a self-test driver.

## Interface
- DEPTH, 2048, words per BRAM; power of two; port byte address is $clog2(DEPTH)+3 bits.
- TIMEOUT, 65535, handshake watchdog limit in cycles; used only with the macro.
- clk  in  1  single clock; also drives the BRAM port clock (integrator ties ps_bram_clk to clk).
- reset  in  1  asynchronous, active-low.
- start  in  1  one-cycle request; honoured only in IDLE or ERR.
- busy  out  1  high in every state except IDLE and ERR.
- done  out  1  one-cycle pulse when a run completes.
- err  out  1  sticky watchdog flag; constant 0 without the macro.
- in_data / in_valid / in_ready  in / in / out  32 / 1 / 1  load stream.
- out_data / out_valid / out_ready  out / out / in  32 / 1 / 1  result stream.
- bram_addr  out  14  byte address; bit 13 selects BRAM 1 (default DEPTH).
- bram_wrdata  out  32  write data.
- bram_we  out  4  write enable; 4'hf or 4'h0 only.
- bram_en  out  1  port enable.
- bram_rddata  in  32  read data, valid one cycle after the request.
- ps_control  out  32  bit 0 is the start/ack level; bits 31:1 are always 0.
- pl_status  in  32  bit 0 is the done level; other bits are ignored.

## Operation
- Reset values: every output is 0, the state is IDLE, and the FIFO is empty.
- IDLE: on start, clear the word counter and go to FILL.
- FILL: in_ready=1.
  - Each in_valid&in_ready beat i writes bram_addr=4*i, bram_we=f, bram_en=1, bram_wrdata=in_data.
  - After beat DEPTH-1, go to WAIT_DONE.
- WAIT_DONE: ps_control[0]=1. When pl_status[0]=1, go to ACK.
- ACK: ps_control[0]=0. When pl_status[0]=0, go to DRAIN.
- DRAIN: read requests go to bram_addr=(DEPTH*4)+4*j, bram_en=1, bram_we=0, for j=0..DEPTH-1.
  - Returned data is written into a 2-entry FIFO that feeds out_*.
  - A read is issued when occupancy+inflight<2, or when it equals 2 and a pop happens this cycle.
  - inflight is 1 if a read was issued in the previous cycle.
  - After the DEPTH-th pop, go to FINISH.
- FINISH: done=1 for one cycle, then go to IDLE.
- Outside write and read cycles: bram_en=0, bram_we=0, bram_addr=0.
- Counters are $clog2(DEPTH)+1 bits. Terminal detection compares against DEPTH; the address never wraps.
- A start seen while busy is ignored.
- If reset is asserted mid-run, all state is abandoned: FIFO flushed, ps_control=0, BRAM contents left as-is.

## Timing
- FILL: one word per cycle while in_valid is held high.
- DRAIN latency: the first read is issued in the first DRAIN cycle; the first out_valid is two cycles later (registered FIFO, no bypass).
- DRAIN throughput: one word per cycle while out_ready stays high.
- out_data must hold stable while out_valid=1 and out_ready=0.
- pl_status is sampled every cycle. Levels are required, not edges; state advances in the cycle after the level is seen.

## Configuration
- HOST_TIMEOUT_EN defined:
  - A cycle counter runs in WAIT_DONE and ACK.
  - On reaching TIMEOUT, go to ERR: ps_control=0, err=1, busy=0.
  - start from ERR clears err and enters FILL.
- HOST_TIMEOUT_EN undefined:
  - No counter; waiting is unbounded.
  - err is tied to 0, ERR is unreachable, and TIMEOUT is unused.

## Structure
- Package bram_host_pkg holds:
  - the state enum (IDLE, FILL, WAIT_DONE, ACK, DRAIN, FINISH, ERR);
  - the BRAM 1 base offset constant (DEPTH*4);
  - the 4'hf full-word enable constant.
- Sub-module bram_host_rdfifo: a 2-entry, 32-bit synchronous FIFO with count output, instantiated once in DRAIN.

## Test plan
- Reset: hold reset=0 with random inputs → all outputs 0; after release, IDLE and busy=0.
- Full run against the reversing accelerator, in_data=i for i=0..2047, out_ready=1:
  - out sequence is 2047,2046,…,0, exactly 2048 beats;
  - one done pulse; ps_control[0] returns to 0.
- Backpressure: in_valid and out_ready random at 50% → outputs identical to the previous scenario, no drops or duplicates, out_data stable while stalled.
- Handshake: the responder raises pl_status[0] 100 cycles after ps_control[0] rises and drops it 20 cycles after ps_control[0] falls.
  - ps_control[0] is held high until the status is seen.
  - No BRAM 1 read occurs before pl_status[0]=0.
- Reset after 500 out beats → next cycle outputs 0 and FIFO empty; a new start completes a clean full run.
- HOST_TIMEOUT_EN with TIMEOUT=16 and pl_status stuck at 0:
  - err=1 and ps_control=0 after 16 WAIT_DONE cycles;
  - start restarts FILL and clears err.
- Same stimulus without HOST_TIMEOUT_EN: the block stays in WAIT_DONE indefinitely and err stays 0.
